// File: rtl/reg_serializer.sv
// reg_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is taken from the
// register block through a valid/ready handshake and shifted out MSB first,
// one bit per cycle. A downstream consumer can stall the stream with hold.
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high reset
//   data_in      word to transmit, sampled only when a load is accepted
//   load_valid   producer has a word on data_in
//   load_ready   block can accept a word (high only in IDLE)
//   hold         downstream stall, freezes shifting while high
//   serial_out   current bit, always the shift register MSB
//   serial_valid serial_out carries a delivered bit this cycle
//   frame_start  high with the first (MSB) bit of a frame
//   done         one-cycle pulse after the last bit has been delivered

module reg_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next-state logic. The last bit is not shifted away: it stays at the MSB
  // through DONE, and cnt stops at WIDTH-1 so it can never wrap in a frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded directly from state so that a stall (hold) drops
  // serial_valid in the same cycle and reset clears everything immediately.
  assign load_ready   = (state_q == IDLE);
  assign serial_valid = (state_q == SHIFT) && !hold;
  assign frame_start  = serial_valid && (cnt_q == '0);
  assign done         = (state_q == DONE);
  assign serial_out   = shreg_q[WIDTH-1];

endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer
//
// Directed bench for reg_serializer (WIDTH = 32). Each scenario task drives
// its own stimulus and compares the packed output vector
// {load_ready, serial_valid, frame_start, serial_out, done} against values
// derived from the transmitted word.

module tb_reg_serializer;

  logic        clk;
  logic        clr;
  logic [31:0] data_in;
  logic        load_valid;
  logic        load_ready;
  logic        hold;
  logic        serial_out;
  logic        serial_valid;
  logic        frame_start;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  reg_serializer #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .hold         (hold),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs set afterwards apply
  // to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {load_ready, serial_valid, frame_start, serial_out, done};
  endfunction

  // Reset at power-up, then an asynchronous reset in the middle of a frame.
  task automatic test_reset();
    logic [31:0] w;
    w = 32'hFFFF_FFFF;
    clr = 1'b1; load_valid = 1'b0; hold = 1'b0; data_in = '0;
    tick();
    #1;
    total_cnt++;
    if (outs() !== 5'b10000) $display("[TB] FAIL reset_initial: got %05b want %05b", outs(), 5'b10000);
    else pass_cnt++;
    clr = 1'b0;
    tick();
    data_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; data_in = '0;
    tick(); tick();
    #1;
    total_cnt++;
    if (outs() !== 5'b01010) $display("[TB] FAIL reset_preshift: got %05b want %05b", outs(), 5'b01010);
    else pass_cnt++;
    // Assert clr between edges: outputs must clear without a clock edge.
    #2 clr = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== 5'b10000) $display("[TB] FAIL reset_async: got %05b want %05b", outs(), 5'b10000);
    else pass_cnt++;
    tick();
    clr = 1'b0;
    tick();
    #1;
    total_cnt++;
    if (outs() !== 5'b10000) $display("[TB] FAIL reset_release: got %05b want %05b", outs(), 5'b10000);
    else pass_cnt++;
  endtask

  // One uninterrupted frame of 0xA5A5_0F0F.
  task automatic test_single_frame();
    logic [31:0] w;
    logic [4:0]  exp;
    w = 32'hA5A5_0F0F;
    data_in = w; load_valid = 1'b1; hold = 1'b0;
    #1;
    total_cnt++;
    if (load_ready !== 1'b1) $display("[TB] FAIL single_ready: got %0b want 1", load_ready);
    else pass_cnt++;
    tick();
    load_valid = 1'b0; data_in = '0;
    for (int k = 0; k < 32; k++) begin
      #1;
      exp = {1'b0, 1'b1, (k == 0), w[31-k], 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL single_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      tick();
    end
    #1;
    exp = {1'b0, 1'b0, 1'b0, w[0], 1'b1};
    total_cnt++;
    if (outs() !== exp) $display("[TB] FAIL single_done: got %05b want %05b", outs(), exp);
    else pass_cnt++;
    tick();
    #1;
    exp = {1'b1, 1'b0, 1'b0, w[0], 1'b0};
    total_cnt++;
    if (outs() !== exp) $display("[TB] FAIL single_ready_back: got %05b want %05b", outs(), exp);
    else pass_cnt++;
  endtask

  // 0x8000_0001 with a 3-cycle stall on bit 10 and a 2-cycle stall on bit 31.
  task automatic test_stall();
    logic [31:0] w;
    logic [4:0]  exp;
    int          nhold;
    w = 32'h8000_0001;
    data_in = w; load_valid = 1'b1; hold = 1'b0;
    tick();
    load_valid = 1'b0; data_in = '0;
    for (int k = 0; k < 32; k++) begin
      nhold = (k == 10) ? 3 : ((k == 31) ? 2 : 0);
      for (int h = 0; h < nhold; h++) begin
        hold = 1'b1;
        #1;
        exp = {1'b0, 1'b0, 1'b0, w[31-k], 1'b0};
        total_cnt++;
        if (outs() !== exp) $display("[TB] FAIL stall_held_bit%0d_c%0d: got %05b want %05b", k, h, outs(), exp);
        else pass_cnt++;
        tick();
      end
      hold = 1'b0;
      #1;
      exp = {1'b0, 1'b1, (k == 0), w[31-k], 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL stall_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      tick();
    end
    #1;
    exp = {1'b0, 1'b0, 1'b0, w[0], 1'b1};
    total_cnt++;
    if (outs() !== exp) $display("[TB] FAIL stall_done: got %05b want %05b", outs(), exp);
    else pass_cnt++;
    tick();
  endtask

  // A load request of all ones while a frame of zeros is shifting.
  task automatic test_load_busy();
    logic [31:0] w;
    logic [4:0]  exp;
    w = 32'h0000_0000;
    data_in = w; load_valid = 1'b1; hold = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 5) begin
        load_valid = 1'b1; data_in = 32'hFFFF_FFFF;
      end else begin
        load_valid = 1'b0; data_in = '0;
      end
      #1;
      exp = {1'b0, 1'b1, (k == 0), 1'b0, 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL busy_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      tick();
    end
    load_valid = 1'b0; data_in = '0;
    #1;
    total_cnt++;
    if (outs() !== 5'b00001) $display("[TB] FAIL busy_done: got %05b want %05b", outs(), 5'b00001);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      total_cnt++;
      if (outs() !== 5'b10000) $display("[TB] FAIL busy_idle_c%0d: got %05b want %05b", c, outs(), 5'b10000);
      else pass_cnt++;
    end
  endtask

  // Reset at bit 15 of 0x1234_5678, then a clean frame of 0xDEAD_BEEF.
  task automatic test_reset_midframe();
    logic [31:0] w;
    logic [4:0]  exp;
    w = 32'h1234_5678;
    data_in = w; load_valid = 1'b1; hold = 1'b0;
    tick();
    load_valid = 1'b0; data_in = '0;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp = {1'b0, 1'b1, (k == 0), w[31-k], 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL midrst_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      if (k < 15) tick();
    end
    clr = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== 5'b10000) $display("[TB] FAIL midrst_async: got %05b want %05b", outs(), 5'b10000);
    else pass_cnt++;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      total_cnt++;
      if (outs() !== 5'b10000) $display("[TB] FAIL midrst_nodone_c%0d: got %05b want %05b", c, outs(), 5'b10000);
      else pass_cnt++;
    end
    w = 32'hDEAD_BEEF;
    data_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; data_in = '0;
    for (int k = 0; k < 32; k++) begin
      #1;
      exp = {1'b0, 1'b1, (k == 0), w[31-k], 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL midrst_reload_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      tick();
    end
    #1;
    exp = {1'b0, 1'b0, 1'b0, w[0], 1'b1};
    total_cnt++;
    if (outs() !== exp) $display("[TB] FAIL midrst_reload_done: got %05b want %05b", outs(), exp);
    else pass_cnt++;
    tick();
  endtask

  // load_valid held high across two words: second load lands WIDTH+2 edges
  // after the first, i.e. one cycle after the DONE cycle.
  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    logic [4:0]  exp;
    int          waits;
    w1 = 32'h0F0F_A5A5;
    w2 = 32'h3C96_E1D2;
    data_in = w1; load_valid = 1'b1; hold = 1'b0;
    tick();
    data_in = w2;
    for (int k = 0; k < 32; k++) begin
      #1;
      exp = {1'b0, 1'b1, (k == 0), w1[31-k], 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL b2b_w1_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      tick();
    end
    #1;
    exp = {1'b0, 1'b0, 1'b0, w1[0], 1'b1};
    total_cnt++;
    if (outs() !== exp) $display("[TB] FAIL b2b_w1_done: got %05b want %05b", outs(), exp);
    else pass_cnt++;
    waits = 0;
    do begin
      tick();
      waits++;
      #1;
    end while (!load_ready && waits < 10);
    total_cnt++;
    if (waits !== 1) $display("[TB] FAIL b2b_gap: got %0d cycles want 1", waits);
    else pass_cnt++;
    tick();
    load_valid = 1'b0; data_in = '0;
    for (int k = 0; k < 32; k++) begin
      #1;
      exp = {1'b0, 1'b1, (k == 0), w2[31-k], 1'b0};
      total_cnt++;
      if (outs() !== exp) $display("[TB] FAIL b2b_w2_bit%0d: got %05b want %05b", k, outs(), exp);
      else pass_cnt++;
      tick();
    end
    #1;
    exp = {1'b0, 1'b0, 1'b0, w2[0], 1'b1};
    total_cnt++;
    if (outs() !== exp) $display("[TB] FAIL b2b_w2_done: got %05b want %05b", outs(), exp);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    clr = 1'b1; load_valid = 1'b0; hold = 1'b0; data_in = '0;
    test_reset();
    test_single_frame();
    test_stall();
    test_load_busy();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
